data_mem_ctrl: RTL and testbench

Data-memory responder for the core's load/store path. It accepts one load or store request at a time from the register-file/execute side: store data, byte address, and a byte/word size. After a fixed, parameterised access latency it returns a single response carrying load data or a store acknowledgement. It owns the word-organised data RAM and handles byte-lane selection, sign extension and error flagging, so the register file sees only whole 32-bit values.

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store request and response bus between the execute stage and the
// data-memory controller.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: one load/store at a time, fixed access latency,
// byte-lane select, sign extension and range/alignment error flagging.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; accepts and latches it
// S_WAIT | latency down-counter running; RAM access on terminal count
// S_RESP | response held on the bus until rsp_ready
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d, byte_q, byte_d, uns_q, uns_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          enter_resp;

  logic [31:0]   mem [DEPTH];

  logic          acc_we, acc_byte, acc_uns, acc_err, mem_we;
  logic [31:0]   acc_addr, acc_wdata, acc_word, wr_word, load_data;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_lane;
  logic [7:0]    rd_byte;

  // State, latency counter, latched request and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; enter_resp marks the edge that performs the RAM access
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    byte_d     = byte_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          byte_d  = bus.req_byte;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access datapath. With LATENCY=1 the access happens on the accepting edge,
  // before the latches hold the request, so the live bus fields are used there.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_byte  = bus.req_byte;
      acc_uns   = bus.req_unsigned;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_byte  = byte_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_idx  = acc_addr[AW+1:2];
    acc_lane = acc_addr[1:0];
    acc_err  = (acc_addr[31:AW+2] != '0) || (!acc_byte && (acc_lane != 2'd0));
    acc_word = mem[acc_idx];
    rd_byte  = acc_word[{acc_lane, 3'b000} +: 8];

    wr_word = acc_wdata;
    if (acc_byte) begin
      wr_word = acc_word;
      wr_word[{acc_lane, 3'b000} +: 8] = acc_wdata[7:0];
    end

    if (!acc_byte)   load_data = acc_word;
    else if (acc_uns) load_data = {24'd0, rd_byte};
    else              load_data = {{24{rd_byte[7]}}, rd_byte};

    mem_we  = enter_resp && acc_we && !acc_err && !rst;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'd0 : load_data;
    end
  end

  // Word RAM; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= wr_word;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a LATENCY=2 and a LATENCY=1 instance checked
// against a byte-addressed reference memory.
module tb_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int PER   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #(PER/2) clk = ~clk;

  data_mem_if bus0 ();
  data_mem_if bus1 ();

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic        req_valid [2];
  logic        req_we [2];
  logic        req_byte [2];
  logic        req_unsigned [2];
  logic        rsp_ready [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        req_ready_w [2];
  logic        rsp_valid_w [2];
  logic        rsp_err_w [2];
  logic [31:0] rsp_rdata_w [2];

  assign bus0.req_valid    = req_valid[0];
  assign bus0.req_we       = req_we[0];
  assign bus0.req_byte     = req_byte[0];
  assign bus0.req_unsigned = req_unsigned[0];
  assign bus0.req_addr     = req_addr[0];
  assign bus0.req_wdata    = req_wdata[0];
  assign bus0.rsp_ready    = rsp_ready[0];
  assign bus1.req_valid    = req_valid[1];
  assign bus1.req_we       = req_we[1];
  assign bus1.req_byte     = req_byte[1];
  assign bus1.req_unsigned = req_unsigned[1];
  assign bus1.req_addr     = req_addr[1];
  assign bus1.req_wdata    = req_wdata[1];
  assign bus1.rsp_ready    = rsp_ready[1];
  assign req_ready_w[0] = bus0.req_ready;
  assign rsp_valid_w[0] = bus0.rsp_valid;
  assign rsp_err_w[0]   = bus0.rsp_err;
  assign rsp_rdata_w[0] = bus0.rsp_rdata;
  assign req_ready_w[1] = bus1.req_ready;
  assign rsp_valid_w[1] = bus1.rsp_valid;
  assign rsp_err_w[1]   = bus1.rsp_err;
  assign rsp_rdata_w[1] = bus1.rsp_rdata;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] mb [2][4*DEPTH];
  time  last_acc [2];
  bit   chain [2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory
  function automatic void model(input int d, input bit we, input bit byt, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
    int b;
    er = (a >= 32'(4*DEPTH)) || (!byt && (a % 4 != 0));
    rd = 32'd0;
    if (er) return;
    b = int'(a);
    if (we) begin
      if (byt) mb[d][b] = wd[7:0];
      else for (int i = 0; i < 4; i++) mb[d][b+i] = wd[8*i +: 8];
    end else if (byt) begin
      rd = uns ? {24'd0, mb[d][b]} : {{24{mb[d][b][7]}}, mb[d][b]};
    end else begin
      rd = {mb[d][b+3], mb[d][b+2], mb[d][b+1], mb[d][b]};
    end
  endfunction

  task automatic issue(input int d, input bit we, input bit byt, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input string tag,
                       output time th);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_byte[d] = byt; req_unsigned[d] = uns;
    req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (!req_ready_w[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_ready"}, 32'(req_ready_w[d]), 32'd1);
    th = $time;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  // n counts edges from the start of the handshake cycle to rsp_valid
  task automatic wait_rsp(input int d, output int n);
    n = 1;
    while (!rsp_valid_w[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic txn(input int d, input bit we, input bit byt, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     input string tag, output logic [31:0] rd, output bit er);
    logic [31:0] erd;
    bit          eer;
    time         th;
    int          n;
    model(d, we, byt, uns, a, wd, erd, eer);
    issue(d, we, byt, uns, a, wd, tag, th);
    rsp_ready[d] = (hold == 0);
    if (chain[d]) chk({tag, " interval"}, 32'((th - last_acc[d]) / PER), 32'(lat(d) + 1));
    last_acc[d] = th;
    wait_rsp(d, n);
    chk({tag, " latency"}, 32'(n), 32'(lat(d)));
    rd = rsp_rdata_w[d];
    er = rsp_err_w[d];
    chk({tag, " rdata"}, rd, erd);
    chk({tag, " err"}, 32'(er), 32'(eer));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = 1'($urandom); req_byte[d] = 1'($urandom);
        req_addr[d] = $urandom_range(0, 4*DEPTH-1); req_wdata[d] = $urandom;
        chk({tag, " bp valid"}, 32'(rsp_valid_w[d]), 32'd1);
        chk({tag, " bp rdata"}, rsp_rdata_w[d], erd);
        chk({tag, " bp err"}, 32'(rsp_err_w[d]), 32'(eer));
        chk({tag, " bp ready"}, 32'(req_ready_w[d]), 32'd0);
      end
      @(negedge clk);
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " release valid"}, 32'(rsp_valid_w[d]), 32'd0);
      chk({tag, " release ready"}, 32'(req_ready_w[d]), 32'd1);
    end
    chain[d] = (hold == 0);
  endtask

  initial begin
    #(200000 * PER);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    bit          er, we, byt, uns;
    time         th;
    int          n, w, hold;
    int          pool [9] = '{0, 1, 2, 3, 4, 5, 6, 7, DEPTH-1};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_byte[d] = 1'b0; req_unsigned[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
      chain[d] = 1'b0; last_acc[d] = 0;
    end

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("reset rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    chk("reset req_ready", 32'(req_ready_w[0]), 32'd1);
    chk("reset rsp_rdata", rsp_rdata_w[0], 32'd0);
    chk("reset rsp_err", 32'(rsp_err_w[0]), 32'd0);
    chk("reset rsp_valid l1", 32'(rsp_valid_w[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Word round trip, byte lanes, errors
    txn(0, 1, 0, 0, 32'h04, 32'hDEADBEEF, 0, "sw 04", rd, er);
    txn(0, 0, 0, 0, 32'h04, 32'h0, 0, "lw 04", rd, er);
    chk("lw 04 value", rd, 32'hDEADBEEF);
    txn(0, 1, 1, 0, 32'h05, 32'h00000080, 0, "sb 05", rd, er);
    txn(0, 0, 0, 0, 32'h04, 32'h0, 0, "lw 04 after sb", rd, er);
    chk("lw 04 after sb value", rd, 32'hDEAD80EF);
    txn(0, 0, 1, 0, 32'h05, 32'h0, 0, "lb 05", rd, er);
    chk("lb 05 value", rd, 32'hFFFFFF80);
    txn(0, 0, 1, 1, 32'h05, 32'h0, 0, "lbu 05", rd, er);
    chk("lbu 05 value", rd, 32'h00000080);
    txn(0, 0, 0, 0, 32'h06, 32'h0, 0, "lw 06", rd, er);
    chk("lw 06 err", 32'(er), 32'd1);
    txn(0, 1, 0, 0, 32'h00, 32'hA5A50001, 0, "sw 00", rd, er);
    txn(0, 1, 0, 0, 32'(4*DEPTH), 32'h12345678, 0, "sw 400", rd, er);
    chk("sw 400 err", 32'(er), 32'd1);
    txn(0, 0, 0, 0, 32'h00, 32'h0, 0, "lw 00", rd, er);
    chk("lw 00 unchanged", rd, 32'hA5A50001);
    txn(0, 1, 0, 0, 32'h10, 32'h11111111, 0, "sw 10", rd, er);

    // Backpressure on a load response
    txn(0, 0, 0, 0, 32'h04, 32'h0, 5, "backpressure", rd, er);

    // Reset while a response is held in RESP
    issue(0, 0, 0, 0, 32'h04, 32'h0, "rst in resp", th);
    rsp_ready[0] = 1'b0;
    wait_rsp(0, n);
    chk("rst in resp reached", 32'(rsp_valid_w[0]), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst in resp valid", 32'(rsp_valid_w[0]), 32'd0);
    chk("rst in resp ready", 32'(req_ready_w[0]), 32'd1);
    chk("rst in resp rdata", rsp_rdata_w[0], 32'd0);
    chk("rst in resp err", 32'(rsp_err_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready[0] = 1'b1;

    // Reset while a store to 0x10 is in WAIT; the store must be dropped
    issue(0, 1, 0, 0, 32'h10, 32'hCAFEF00D, "rst in wait", th);
    #2 rst = 1'b1;
    #1;
    chk("rst in wait valid", 32'(rsp_valid_w[0]), 32'd0);
    chk("rst in wait ready", 32'(req_ready_w[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chain[0] = 1'b0;
    txn(0, 0, 0, 0, 32'h10, 32'h0, 0, "lw 10 after drop", rd, er);
    chk("lw 10 after drop value", rd, 32'h11111111);

    // LATENCY=1: back-to-back store/load pairs
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      txn(1, 1, 0, 0, a, $urandom, 0, $sformatf("l1 sw %0d", i), rd, er);
      txn(1, 0, 0, 0, a, 32'h0, 0, $sformatf("l1 lw %0d", i), rd, er);
    end

    // Randomized traffic against the reference memory
    for (int d = 0; d < 2; d++) begin
      chain[d] = 1'b0;
      for (int i = 0; i < 9; i++)
        txn(d, 1, 0, 0, 32'(pool[i] * 4), $urandom, 0, $sformatf("init%0d.%0d", d, i), rd, er);
      for (int k = 0; k < 40; k++) begin
        we  = 1'($urandom);
        byt = 1'($urandom);
        uns = 1'($urandom);
        w   = pool[$urandom_range(0, 8)];
        a   = 32'(w * 4) + (byt ? 32'($urandom_range(0, 3)) : 32'd0);
        case ($urandom_range(0, 9))
          0: a = 32'(4*DEPTH) + 32'($urandom_range(0, 4095));
          1: a = $urandom | 32'h8000_0000;
          2: if (!byt) a = 32'(w * 4) + 32'($urandom_range(1, 3));
          default: ;
        endcase
        hold = ($urandom_range(0, 5) == 0) ? 2 : 0;
        txn(d, we, byt, uns, a, $urandom, hold, $sformatf("rand%0d.%0d", d, k), rd, er);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
